rptr_empty: RTL and testbench

Read-side pointer and empty-flag controller for the asynchronous FIFO, the read-domain counterpart of the `r2w` read-to-write pointer synchronizer. It does the following:
- Brings the write domain's Gray-coded write pointer into the read clock through an internal two-flop synchronizer.
- Maintains the binary and Gray read pointers.
- Drives the dual-port RAM read address.
- Produces a registered, glitch-free empty flag.

Its `graycode_rptr` output is the signal `r2w` carries back into the write domain.

---
 rtl/rptr_empty.sv | 60 ++++++
 tb/tb_rptr_empty.sv | 124 ++++++++++++
 2 files changed

// File: rtl/rptr_empty.sv
// rptr_empty: read-side pointer and registered empty flag for an async FIFO.
// Brings the write-domain Gray pointer in through a two-flop synchronizer,
// keeps the binary/Gray read pointers and drives the RAM read address.
// Ports:
//   clk           read-domain clock
//   rst           asynchronous reset, active low
//   rinc          read request, honoured only while rempty is low
//   graycode_wptr Gray write pointer from the write domain (asynchronous)
//   raddr         RAM read address
//   graycode_rptr registered Gray read pointer, returned to the write domain
//   rempty        registered empty flag
//   rcount        registered fill level (only when RPTR_RCOUNT_EN is defined)
module rptr_empty #(
    parameter int ADDRSIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   graycode_wptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   graycode_rptr,
`ifdef RPTR_RCOUNT_EN
    output logic [ADDRSIZE:0]   rcount,
`endif
    output logic                rempty
);
    logic [ADDRSIZE:0] wq1, wq2, rbin, rbinnext, rgraynext;
    assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rinc & ~rempty};
    assign rgraynext = (rbinnext >> 1) ^ rbinnext;
    assign raddr     = rbin[ADDRSIZE-1:0];
`ifdef RPTR_RCOUNT_EN
    // each binary bit is the XOR of all Gray bits at or above it
    logic [ADDRSIZE:0] wbin;
    for (genvar g = 0; g <= ADDRSIZE; g++) begin : g_g2b
        assign wbin[g] = ^(wq2 >> g);
    end
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wq1           <= '0;
            wq2           <= '0;
            rbin          <= '0;
            graycode_rptr <= '0;
            rempty        <= 1'b1;
`ifdef RPTR_RCOUNT_EN
            rcount        <= '0;
`endif
        end else begin
            wq1           <= graycode_wptr;
            wq2           <= wq1;
            rbin          <= rbinnext;
            graycode_rptr <= rgraynext;
            // compares against the pre-edge wq2, so the flag only ever clears late
            rempty        <= (rgraynext == wq2);
`ifdef RPTR_RCOUNT_EN
            rcount        <= wbin - rbinnext;
`endif
        end
    end
endmodule

// File: tb/tb_rptr_empty.sv
// tb_rptr_empty: directed and random checks of rptr_empty against an integer-count model.
module tb_rptr_empty;
    localparam int A = 4;
    localparam int M = 32;
    logic         clk = 0, rst = 1, rinc = 0;
    logic [A:0]   wg = '0;
    logic [A-1:0] raddr;
    logic [A:0]   grp;
    logic         rempty;
`ifdef RPTR_RCOUNT_EN
    logic [A:0]   rcount;
`endif

    rptr_empty #(.ADDRSIZE(A)) dut (
        .clk(clk),
        .rst(rst),
        .rinc(rinc),
        .graycode_wptr(wg),
        .raddr(raddr),
        .graycode_rptr(grp),
`ifdef RPTR_RCOUNT_EN
        .rcount(rcount),
`endif
        .rempty(rempty)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    // model: w = entries written, r = entries read (mod 32); s1/s2 = write count as seen through the sync
    int w = 0, r = 0, s1 = 0, s2 = 0, cnt = 0;
    bit emp = 1;

    function automatic logic [A:0] gray(int v);
        logic [A:0] t;
        t = v[A:0];
        return t ^ (t >> 1);
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("raddr", int'(raddr), r % 16);
        chk("graycode_rptr", int'(grp), int'(gray(r)));
        chk("rempty", int'(rempty), int'(emp));
`ifdef RPTR_RCOUNT_EN
        chk("rcount", int'(rcount), cnt);
`endif
    endtask

    task automatic setw(int v);
        w  = v % M;
        wg = gray(w);
    endtask

    task automatic step(bit rd);
        bit acc;
        rinc = rd;
        @(posedge clk);
        acc = rd && !emp;
        r   = (r + int'(acc)) % M;
        emp = (r == s2);
        cnt = (s2 - r + M) % M;
        s2  = s1;
        s1  = w;
        #1;
        check_all();
    endtask

    // asserts reset between edges and checks outputs before any clock arrives
    task automatic do_reset();
        rinc = 0;
        #2 rst = 0;
        r = 0; s1 = 0; s2 = 0; cnt = 0; emp = 1;
        #1 check_all();
        #2 rst = 1;
    endtask

    initial begin
        #1 rst = 0;
        #1 check_all();
        #1 rst = 1;
        // fill to 3: flag clears exactly on the third edge
        setw(3);
        step(0); chk("empty_edge1", int'(rempty), 1);
        step(0); chk("empty_edge2", int'(rempty), 1);
        step(0); chk("empty_edge3", int'(rempty), 0);
        // four requests, the last one ignored
        for (int i = 0; i < 4; i++) step(1);
        chk("underflow_raddr", int'(raddr), 3);
        chk("underflow_gray", int'(grp), 2);
        // full wrap of 16 entries
        do_reset();
        setw(16);
        for (int i = 0; i < 3; i++) step(0);
        for (int i = 0; i < 16; i++) step(1);
        chk("wrap_gray", int'(grp), 5'b11000);
        chk("wrap_raddr", int'(raddr), 0);
        chk("wrap_empty", int'(rempty), 1);
        // reset mid-operation
        do_reset();
        setw(5);
        for (int i = 0; i < 3; i++) step(0);
        step(1); step(1);
        do_reset();
        for (int i = 0; i < 3; i++) step(0);
        chk("post_reset_empty", int'(rempty), 0);
        // random traffic, writer never overfills
        setw(0);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) != 0 && (w - r + M) % M < 16) setw(w + 1);
            step(bit'($urandom_range(0, 1)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
